// File: rtl/pong_match_ctrl_pkg.sv
// Shared definitions for the pong match sequencer: state codes, winner codes,
// and a small helper for sizing the shared delay timer.
package pong_match_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_POINT = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_edge_detect.sv
// Rising-edge detector for a debounced, clk-synchronous button level.
// The pulse is registered, so the event is seen by downstream logic on the
// cycle after the edge is sampled; a held button yields exactly one pulse.
module pong_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev_q;

  // Track the previous level and register the 0->1 transition as a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      prev_q <= level;
      rise   <= level & ~prev_q;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level sequencer: owns the scores, the serve/point delay timer and the
// ball-engine controls. State is exported on state_out for debug LEDs.
//
// Interface semantics: there are no valid/ready handshakes. p1_point/p2_point
// are single-cycle strobes acted on only in PLAY (p1 wins a tie); button
// events are single-cycle pulses from pong_edge_detect. ball_recenter and
// paddle_reset are single-cycle strobes; every other output is a level.
module pong_match_ctrl
  import pong_match_ctrl_pkg::*;
#(
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 50_000_000,
  parameter int POINT_DELAY = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic               ball_run,
  output logic               ball_recenter,
  output logic               serve_dir,
  output logic               paddle_reset,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic [2:0]         state_out
);

  localparam int MAX_DELAY = max_int(SERVE_DELAY, POINT_DELAY);
  localparam int TIMER_W   = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_DELAY - 1);
  localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  logic start_rise, pause_rise;

  pong_edge_detect u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_start),
    .rise  (start_rise)
  );

  pong_edge_detect u_pause_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (btn_pause),
    .rise  (pause_rise)
  );

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [SCORE_W-1:0] p1_d, p2_d;
  logic [1:0]         win_d;
  logic               dir_d, rec_d, pad_d;

  // Register the FSM state together with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      p1_score      <= '0;
      p2_score      <= '0;
      winner        <= WIN_NONE;
      serve_dir     <= 1'b0;
      ball_recenter <= 1'b0;
      paddle_reset  <= 1'b0;
      ball_run      <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      p1_score      <= p1_d;
      p2_score      <= p2_d;
      winner        <= win_d;
      serve_dir     <= dir_d;
      ball_recenter <= rec_d;
      paddle_reset  <= pad_d;
      ball_run      <= (state_d == ST_PLAY);
    end
  end

  // Next-state, timer, score and strobe decisions.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    p1_d    = p1_score;
    p2_d    = p2_score;
    win_d   = winner;
    dir_d   = serve_dir;
    rec_d   = 1'b0;
    pad_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          p1_d    = '0;
          p2_d    = '0;
          win_d   = WIN_NONE;
          dir_d   = 1'b0;
          pad_d   = 1'b1;
          rec_d   = 1'b1;
          timer_d = SERVE_LOAD;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (timer_q == '0) state_d = ST_PLAY;
        else               timer_d = timer_q - 1'b1;
      end
      ST_PLAY: begin
        if (p1_point) begin
          if (p1_score != WIN_VAL) p1_d = p1_score + 1'b1;
          dir_d   = 1'b0;
          timer_d = POINT_LOAD;
          state_d = ST_POINT;
        end else if (p2_point) begin
          if (p2_score != WIN_VAL) p2_d = p2_score + 1'b1;
          dir_d   = 1'b1;
          timer_d = POINT_LOAD;
          state_d = ST_POINT;
        end else if (pause_rise) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (pause_rise) state_d = ST_PLAY;
      end
      ST_POINT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else if (p1_score == WIN_VAL) begin
          win_d   = WIN_P1;
          state_d = ST_OVER;
        end else if (p2_score == WIN_VAL) begin
          win_d   = WIN_P2;
          state_d = ST_OVER;
        end else begin
          rec_d   = 1'b1;
          timer_d = SERVE_LOAD;
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl with short delays. Expected output snapshots are
// pushed to exp_q as each cycle's stimulus is driven and popped/compared on
// the following falling edge.
module tb_pong_match_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_POINT = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n, btn_start, btn_pause, p1_point, p2_point;
  logic       ball_run, ball_recenter, serve_dir, paddle_reset;
  logic [2:0] p1_score, p2_score;
  logic [1:0] winner;
  logic [2:0] state_out;

  logic [14:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Expected match bookkeeping, updated from the stimulus.
  logic [2:0] e_p1 = '0, e_p2 = '0;
  logic       e_dir = 1'b0;
  logic [1:0] e_win = '0;

  pong_match_ctrl #(
    .SCORE_W(3), .WIN_SCORE(3), .SERVE_DELAY(4), .POINT_DELAY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
    .p1_point(p1_point), .p2_point(p2_point), .ball_run(ball_run),
    .ball_recenter(ball_recenter), .serve_dir(serve_dir),
    .paddle_reset(paddle_reset), .p1_score(p1_score), .p2_score(p2_score),
    .winner(winner), .state_out(state_out)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] obs();
    return {ball_run, ball_recenter, serve_dir, paddle_reset,
            p1_score, p2_score, winner, state_out};
  endfunction

  function automatic logic [14:0] mk(input logic run, input logic rec,
                                     input logic pad, input logic [2:0] st);
    return {run, rec, e_dir, pad, e_p1, e_p2, e_win, st};
  endfunction

  task automatic check(input string tag, input logic [14:0] got,
                       input logic [14:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got run/rec/dir/pad/p1/p2/win/st=%b expected %b",
               tag, got, exp);
    end
  endtask

  // One clock: queue the expected snapshot, advance, compare on negedge.
  task automatic tick(input string tag, input logic run, input logic rec,
                      input logic pad, input logic [2:0] st);
    logic [14:0] e;
    exp_q.push_back(mk(run, rec, pad, st));
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, obs(), e);
  endtask

  task automatic serve_to_play(input string tag, input logic pad);
    tick({tag, "_srv0"}, 1'b0, 1'b1, pad, S_SERVE);
    for (int i = 1; i < 4; i++) tick({tag, "_srv"}, 1'b0, 1'b0, 1'b0, S_SERVE);
    tick({tag, "_play"}, 1'b1, 1'b0, 1'b0, S_PLAY);
  endtask

  // Start from IDLE/OVER; hold keeps btn_start high afterwards.
  task automatic start_match(input string tag, input logic [2:0] from_st,
                             input bit hold);
    btn_start = 1'b1;
    tick({tag, "_lat"}, 1'b0, 1'b0, 1'b0, from_st);
    e_p1 = '0; e_p2 = '0; e_dir = 1'b0; e_win = 2'b00;
    serve_to_play(tag, 1'b1);
    if (!hold) btn_start = 1'b0;
  endtask

  // Score a point from PLAY (who=1/2, both=1 pulses both strobes).
  task automatic score(input string tag, input int who, input bit both);
    p1_point = (who == 1) || both;
    p2_point = (who == 2) || both;
    if (who == 1) begin e_p1 = e_p1 + 1'b1; e_dir = 1'b0; end
    else          begin e_p2 = e_p2 + 1'b1; e_dir = 1'b1; end
    tick({tag, "_pt0"}, 1'b0, 1'b0, 1'b0, S_POINT);
    p1_point = 1'b0;
    p2_point = 1'b0;
    tick({tag, "_pt1"}, 1'b0, 1'b0, 1'b0, S_POINT);
    tick({tag, "_pt2"}, 1'b0, 1'b0, 1'b0, S_POINT);
    if (e_p1 == 3'd3) begin
      e_win = 2'b01;
      tick({tag, "_over"}, 1'b0, 1'b0, 1'b0, S_OVER);
    end else if (e_p2 == 3'd3) begin
      e_win = 2'b10;
      tick({tag, "_over"}, 1'b0, 1'b0, 1'b0, S_OVER);
    end else begin
      serve_to_play(tag, 1'b0);
    end
  endtask

  initial begin
    logic [14:0] e;
    rst_n = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    p1_point = 1'b0; p2_point = 1'b0;
    @(posedge clk);
    tick("reset", 1'b0, 1'b0, 1'b0, S_IDLE);
    rst_n = 1'b1;
    tick("idle", 1'b0, 1'b0, 1'b0, S_IDLE);

    // 1: start, paddle reset and recenter pulses, PLAY after 4 serve cycles.
    start_match("t1", S_IDLE, 1'b0);

    // 2: player 2 scores.
    score("t2", 2, 1'b0);

    // 3: simultaneous points, p1 wins the tie.
    score("t3", 1, 1'b1);

    // 4: pause, ignored point, held pause, resume.
    btn_pause = 1'b1;
    tick("t4_lat", 1'b1, 1'b0, 1'b0, S_PLAY);
    tick("t4_pause", 1'b0, 1'b0, 1'b0, S_PAUSE);
    p1_point = 1'b1;
    tick("t4_pt_ign", 1'b0, 1'b0, 1'b0, S_PAUSE);
    p1_point = 1'b0;
    for (int i = 0; i < 3; i++) tick("t4_held", 1'b0, 1'b0, 1'b0, S_PAUSE);
    btn_pause = 1'b0;
    tick("t4_rel", 1'b0, 1'b0, 1'b0, S_PAUSE);
    btn_pause = 1'b1;
    tick("t4_lat2", 1'b0, 1'b0, 1'b0, S_PAUSE);
    btn_pause = 1'b0;
    tick("t4_resume", 1'b1, 1'b0, 1'b0, S_PLAY);

    // 5: p1 reaches 3 -> OVER, further points ignored, restart clears.
    score("t5a", 1, 1'b0);
    score("t5b", 1, 1'b0);
    p1_point = 1'b1;
    tick("t5_ign1", 1'b0, 1'b0, 1'b0, S_OVER);
    p1_point = 1'b0; p2_point = 1'b1;
    tick("t5_ign2", 1'b0, 1'b0, 1'b0, S_OVER);
    p2_point = 1'b0;
    start_match("t5", S_OVER, 1'b0);

    // 6a: asynchronous reset in the middle of POINT.
    p2_point = 1'b1;
    e_p2 = e_p2 + 1'b1; e_dir = 1'b1;
    tick("t6_pt", 1'b0, 1'b0, 1'b0, S_POINT);
    p2_point = 1'b0;
    e_p1 = '0; e_p2 = '0; e_dir = 1'b0; e_win = 2'b00;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, S_IDLE));
    rst_n = 1'b0;
    #1;
    e = exp_q.pop_front();
    check("t6_async_rst", obs(), e);
    @(negedge clk);
    rst_n = 1'b1;
    tick("t6_idle", 1'b0, 1'b0, 1'b0, S_IDLE);

    // 6b: btn_start held through a whole match gives one start only.
    start_match("t6", S_IDLE, 1'b1);
    score("t6a", 1, 1'b0);
    score("t6b", 1, 1'b0);
    score("t6c", 1, 1'b0);
    for (int i = 0; i < 20; i++) tick("t6_hold", 1'b0, 1'b0, 1'b0, S_OVER);
    btn_start = 1'b0;
    tick("t6_rel", 1'b0, 1'b0, 1'b0, S_OVER);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
